// File: rtl/operand_entry_seq.sv
// Operand-entry sequencer: debounces the load button and steps operand A, then
// operand B plus opcode, into held registers qualified by a valid flag.
module operand_entry_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned OP_W    = 3,
  parameter int unsigned DEB_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_load,
  input  logic             btn_clear,
  input  logic [WIDTH-1:0] sw,
  input  logic [OP_W-1:0]  op_sw,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [OP_W-1:0]  op,
  output logic             valid,
  output logic [1:0]       state
);

  localparam int unsigned      CNT_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT_B = 2'd1;
  localparam logic [1:0] READY  = 2'd2;

  logic             sync_q;
  logic             btn_s;
  logic             db;
  logic             db_q;
  logic [CNT_W-1:0] cnt;
  logic             press;

  logic [1:0]       state_n;
  logic [WIDTH-1:0] reg_a_n;
  logic [WIDTH-1:0] reg_b_n;
  logic [OP_W-1:0]  op_n;
  logic             valid_n;

  // Two-flop synchroniser for the raw button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_q <= btn_load;
      btn_s  <= sync_q;
    end
  end

  // Debounce: level flips only after DEB_CYC consecutive disagreeing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      db   <= 1'b0;
      db_q <= 1'b0;
    end else begin
      db_q <= db;
      if (btn_s == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt <= '0;
        db  <= ~db;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = db & ~db_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      reg_a <= '0;
      reg_b <= '0;
      op    <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      reg_a <= reg_a_n;
      reg_b <= reg_b_n;
      op    <= op_n;
      valid <= valid_n;
    end
  end

  // Clear wins over a coincident press; the press is dropped
  always_comb begin
    state_n = state;
    reg_a_n = reg_a;
    reg_b_n = reg_b;
    op_n    = op;
    valid_n = valid;
    if (btn_clear) begin
      state_n = IDLE;
      valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            state_n = WAIT_B;
            reg_a_n = sw;
          end
        end
        WAIT_B: begin
          if (press) begin
            state_n = READY;
            reg_b_n = sw;
            op_n    = op_sw;
            valid_n = 1'b1;
          end
        end
        READY: begin
          if (press) begin
            state_n = WAIT_B;
            reg_a_n = sw;
            valid_n = 1'b0;
          end
        end
        default: begin
          state_n = IDLE;
          valid_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_entry_seq.sv
// Self-checking bench for operand_entry_seq: table-driven press sequence with a
// scoreboard queue, plus hand-written bounce, clear and async-reset cases.
module tb_operand_entry_seq;

  localparam int unsigned DEB   = 4;
  localparam int          LAT_E = DEB + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_load;
  logic       btn_clear;
  logic [7:0] sw;
  logic [2:0] op_sw;
  logic [7:0] reg_a;
  logic [7:0] reg_b;
  logic [2:0] op;
  logic       valid;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] sw;
    logic [2:0] op_sw;
    int         hold;
    logic [1:0] prev;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [2:0] eop;
    logic       ev;
    logic [1:0] es;
  } vec_t;

  vec_t tbl[6];
  vec_t exp_q[$];

  operand_entry_seq #(.WIDTH(8), .OP_W(3), .DEB_CYC(DEB)) dut (
    .clk(clk), .rst(rst), .btn_load(btn_load), .btn_clear(btn_clear),
    .sw(sw), .op_sw(op_sw), .reg_a(reg_a), .reg_b(reg_b), .op(op),
    .valid(valid), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one press, check exact capture latency against the scoreboard, then release
  task automatic do_press(input vec_t v);
    vec_t e;
    exp_q.push_back(v);
    @(negedge clk);
    sw = v.sw; op_sw = v.op_sw; btn_load = 1'b1;
    for (int i = 1; i <= v.hold; i++) begin
      @(posedge clk); #1;
      if (i == LAT_E - 1) chk("pre_capture_state", 8'(state), 8'(v.prev));
      if (i == LAT_E) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 8'(1), 8'(0));
        end else begin
          e = exp_q.pop_front();
          chk("cap_reg_a", reg_a, e.ea);
          chk("cap_reg_b", reg_b, e.eb);
          chk("cap_op", 8'(op), 8'(e.eop));
          chk("cap_valid", 8'(valid), 8'(e.ev));
          chk("cap_state", 8'(state), 8'(e.es));
        end
        sw = ~v.sw; op_sw = ~v.op_sw;
      end
      if (i == v.hold) begin
        chk("held_state", 8'(state), 8'(v.es));
        chk("held_reg_a", reg_a, v.ea);
      end
    end
    @(negedge clk);
    btn_load = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    bit moved;
    tbl[0] = '{8'h3C, 3'd5, 10, 2'd0, 8'h3C, 8'h00, 3'd0, 1'b0, 2'd1};
    tbl[1] = '{8'hA5, 3'd2, 12, 2'd1, 8'h3C, 8'hA5, 3'd2, 1'b1, 2'd2};
    tbl[2] = '{8'hFF, 3'd7, 12, 2'd2, 8'hFF, 8'hA5, 3'd2, 1'b0, 2'd1};
    tbl[3] = '{8'h11, 3'd3, 12, 2'd1, 8'hFF, 8'h11, 3'd3, 1'b1, 2'd2};
    tbl[4] = '{8'h22, 3'd1, 12, 2'd2, 8'h22, 8'h11, 3'd3, 1'b0, 2'd1};
    tbl[5] = '{8'h5A, 3'd4, 50, 2'd0, 8'h5A, 8'h11, 3'd3, 1'b0, 2'd1};

    rst = 1'b1; btn_load = 1'b0; btn_clear = 1'b0; sw = 8'h00; op_sw = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reg_a", reg_a, 8'h00);
    chk("rst_valid", 8'(valid), 8'(0));
    chk("rst_state", 8'(state), 8'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Bounce: 3 high, 1 low, 3 high must not register a press
    @(negedge clk);
    sw = 8'hEE; btn_load = 1'b1;
    repeat (3) @(negedge clk);
    btn_load = 1'b0;
    @(negedge clk);
    btn_load = 1'b1;
    repeat (3) @(negedge clk);
    btn_load = 1'b0;
    moved = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (state != 2'd0 || reg_a != 8'h00) moved = 1'b1;
    end
    chk("bounce_reject", 8'(moved), 8'(0));

    for (int i = 0; i < 5; i++) do_press(tbl[i]);

    // Clear coincident with the press pulse in WAIT_B
    @(negedge clk);
    sw = 8'h77; op_sw = 3'd6; btn_load = 1'b1;
    repeat (LAT_E - 1) @(posedge clk);
    #1;
    chk("clr_pre_state", 8'(state), 8'(1));
    @(negedge clk);
    btn_clear = 1'b1;
    @(posedge clk); #1;
    btn_clear = 1'b0;
    chk("clr_state", 8'(state), 8'(0));
    chk("clr_valid", 8'(valid), 8'(0));
    chk("clr_reg_b", reg_b, 8'h11);
    chk("clr_reg_a", reg_a, 8'h22);
    chk("clr_op", 8'(op), 8'(3));
    repeat (40) @(posedge clk);
    #1;
    chk("clr_no_repress", 8'(state), 8'(0));
    @(negedge clk);
    btn_load = 1'b0;
    repeat (10) @(posedge clk);

    // Held button: one capture only, even as sw changes afterwards
    do_press(tbl[5]);

    // Async reset mid-WAIT_B, observed before the next clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_reg_a", reg_a, 8'h00);
    chk("arst_reg_b", reg_b, 8'h00);
    chk("arst_op", 8'(op), 8'(0));
    chk("arst_valid", 8'(valid), 8'(0));
    chk("arst_state", 8'(state), 8'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    chk("sb_drained", 8'(exp_q.size()), 8'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
